// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 accumulation controller: FSM states and FP32 field helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam int          FP32_EXP_MSB = 30;
  localparam int          FP32_EXP_LSB = 23;

  // NaN = all-ones exponent with a nonzero fraction (infinity excluded).
  function automatic logic is_nan(input logic [31:0] x);
    return (&x[FP32_EXP_MSB:FP32_EXP_LSB]) && (|x[FP32_EXP_LSB-1:0]);
  endfunction

endpackage

// File: rtl/fp_accum_ctrl_sat_counter.sv
// Saturating element counter: synchronous clear, load-to-1 and increment, never wraps.
module sat_counter
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_count <= '0;
    else if (i_clear)                 r_count <= '0;
    else if (i_load)                  r_count <= WIDTH'(1);
    else if (i_inc && r_count != '1)  r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/fp_accum_ctrl.sv
// Streaming FP32 accumulation controller around an external combinational add/sub unit.
// Optional sticky NaN tracking is enabled by defining FP_ACCUM_NAN_STICKY_EN.
module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sub,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  output logic                  add_symbol,
  input  logic [DATA_WIDTH-1:0] add_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_nan
);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  w_accept;
  logic                  w_force_nan;
  logic [DATA_WIDTH-1:0] w_first;

  assign in_ready   = (r_state != HOLD) && !clear;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == HOLD);
  assign out_data   = r_acc;
  assign add_a      = r_acc;
  assign add_b      = in_data;
  assign add_symbol = in_sub;
  // First element bypasses the adder; subtraction from zero is just a sign flip.
  assign w_first    = in_sub ? {~in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-2:0]} : in_data;

`ifdef FP_ACCUM_NAN_STICKY_EN
  logic r_nan;
  logic w_elem_nan;

  assign w_elem_nan  = is_nan(in_data);
  assign w_force_nan = r_nan || w_elem_nan;
  assign out_nan     = r_nan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_nan <= 1'b0;
    else if (clear)                           r_nan <= 1'b0;
    else if (r_state == HOLD && out_ready)    r_nan <= 1'b0;
    else if (w_accept && w_elem_nan)          r_nan <= 1'b1;
  end
`else
  assign w_force_nan = 1'b0;
  assign out_nan     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_acc   <= w_force_nan ? FP32_QNAN : w_first;
          r_state <= in_last ? HOLD : ACCUM;
        end
        ACCUM: if (w_accept) begin
          r_acc   <= w_force_nan ? FP32_QNAN : add_result;
          r_state <= in_last ? HOLD : ACCUM;
        end
        HOLD: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_count (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_load  (w_accept && r_state == IDLE),
    .i_inc   (w_accept && r_state == ACCUM),
    .o_count (out_count)
  );

endmodule
